// File: rtl/light_selector_fade_if.sv
// Control and light bundle between the board-side driver and light_selector_fade.
// master: drives mode and button, observes light, colour and busy.
// slave : the selector itself, which consumes mode/button and produces light/colour/busy.
interface light_selector_fade_if #(
    parameter int CW = 8
);
    logic [1:0]      mode;    // 0=white 1=manual colour 2=auto cycle 3=off
    logic            button;  // synchronous level, rising edge steps colour in manual mode
    logic [3*CW-1:0] light;   // registered {R,G,B}
    logic [2:0]      colour;  // current colour index 1..6
    logic            busy;    // light has not yet reached its target

    modport master (
        output mode, button,
        input  light, colour, busy
    );

    modport slave (
        input  mode, button,
        output light, colour, busy
    );
endinterface

// File: rtl/light_selector_fade.sv
// RGB light selector (white / manual colour / auto cycle / off) with per-channel fade.
// Latency: target follows mode/colour combinationally; light moves one STEP per edge.
// Backpressure: none; free-running, inputs sampled every cycle.
//
// Ports: clk (rising edge), rst (synchronous, active-low),
//        bus (slave modport): mode, button in; light, colour, busy out.
module light_selector_fade #(
    parameter int CW          = 8,
    parameter int STEP        = 16,
    parameter int AUTO_PERIOD = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    light_selector_fade_if.slave  bus
);
    localparam int              CNTW     = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [CW:0]     STEP_W   = (CW+1)'(STEP);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_WHITE  = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_AUTO   = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    mode_e           mode_s;
    logic [3*CW-1:0] light_q, light_d;
    logic [3*CW-1:0] target;
    logic [2:0]      colour_q, colour_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            btn_prev_q, btn_prev_d;
    logic            btn_edge;
    logic            advance;

    // Per-channel slew scratch, one bit wider than a channel so sums never wrap.
    logic [CW:0]     cur, tgt, up, lo, nxt;

    assign mode_s = mode_e'(bus.mode);

    // Each colour bit selects its channel at full scale: [2]=R, [1]=G, [0]=B.
    always_comb begin
        target = '0;
        case (mode_s)
            MODE_WHITE:             target = '1;
            MODE_MANUAL, MODE_AUTO: target = {{CW{colour_q[2]}}, {CW{colour_q[1]}}, {CW{colour_q[0]}}};
            default:                target = '0;
        endcase
    end

    always_comb begin
        btn_edge   = bus.button & ~btn_prev_q;
        btn_prev_d = bus.button;
        advance    = 1'b0;
        cnt_d      = '0;

        if (mode_s == MODE_MANUAL) begin
            advance = btn_edge;
        end else if (mode_s == MODE_AUTO) begin
            if (cnt_q == CNT_LAST) begin
                advance = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end

        colour_d = colour_q;
        if (advance) begin
            colour_d = (colour_q == 3'd6) ? 3'd1 : colour_q + 3'd1;
        end
    end

    // Moving up clamps at the target once the sum overshoots; moving down only
    // subtracts STEP when the result stays at or above the target, so an
    // unsigned underflow is never formed.
    always_comb begin
        light_d = light_q;
        cur     = '0;
        tgt     = '0;
        up      = '0;
        lo      = '0;
        nxt     = '0;
        for (int i = 0; i < 3; i++) begin
            cur = {1'b0, light_q[i*CW +: CW]};
            tgt = {1'b0, target[i*CW +: CW]};
            up  = cur + STEP_W;
            lo  = tgt + STEP_W;
            if (cur < tgt) begin
                nxt = (up > tgt) ? tgt : up;
            end else if (cur > tgt) begin
                nxt = (cur >= lo) ? (cur - STEP_W) : tgt;
            end else begin
                nxt = cur;
            end
            light_d[i*CW +: CW] = nxt[CW-1:0];
        end
    end

    // btn_prev resets high so a button already held at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            light_q    <= '0;
            colour_q   <= 3'd1;
            cnt_q      <= '0;
            btn_prev_q <= 1'b1;
        end else begin
            light_q    <= light_d;
            colour_q   <= colour_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign bus.light  = light_q;
    assign bus.colour = colour_q;
    assign bus.busy   = (light_q != target);
endmodule
